// File: rtl/ifu_pkg.sv
// Shared IFU types and constants: cache geometry, plru handshake struct,
// cache controller state encoding and tag-array entry layout.
package ifu_pkg;

    localparam int WAYS_NUM = 16;
    localparam int WAY_W    = $clog2(WAYS_NUM);
    localparam int ADDR_W   = 32;
    localparam int LINE_W   = 128;
    localparam int OFFS_W   = 4;
    localparam int TAG_W    = ADDR_W - OFFS_W;

    typedef struct packed {
        logic             update_tree;
        logic             cache_miss;
        logic [WAY_W-1:0] hit_cl;
    } t_cache_ctrl_plru;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_WAIT
    } t_ifu_cache_state;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } t_ifu_tag_entry;

endpackage

// File: rtl/ifu_tag_cmp.sv
// Fully associative tag compare: one-hot match vector, hit flag and the
// binary index of the matching way (meaningful only when exactly one matches).
module ifu_tag_cmp
    import ifu_pkg::*;
(
    input  t_ifu_tag_entry [WAYS_NUM-1:0] entries,
    input  logic [TAG_W-1:0]              tag,
    output logic [WAYS_NUM-1:0]           match,
    output logic                          hit,
    output logic [WAY_W-1:0]              way
);

    always_comb begin
        match = '0;
        way   = '0;
        for (int i = 0; i < WAYS_NUM; i++) begin
            match[i] = entries[i].valid && (entries[i].tag == tag);
            // OR-reduction encoder; relies on the one-hot invariant
            if (match[i]) way = way | WAY_W'(i);
        end
    end

    assign hit = |match;

endmodule

// File: rtl/ifu_cache_ctrl.sv
// IFU instruction-cache controller: 16-way fully associative, single-beat refill,
// drives the plru update interface. Perf counters built only with IFU_CACHE_PERF_CNT_EN.
module ifu_cache_ctrl
    import ifu_pkg::WAYS_NUM, ifu_pkg::WAY_W, ifu_pkg::TAG_W, ifu_pkg::OFFS_W,
           ifu_pkg::t_cache_ctrl_plru, ifu_pkg::t_ifu_cache_state, ifu_pkg::t_ifu_tag_entry,
           ifu_pkg::IDLE, ifu_pkg::LOOKUP, ifu_pkg::MISS_REQ, ifu_pkg::MISS_WAIT;
#(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int INSTR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                fetch_req_valid,
    input  logic [ADDR_W-1:0]   fetch_req_addr,
    output logic                fetch_req_ready,
    output logic                fetch_rsp_valid,
    output logic [INSTR_W-1:0]  fetch_rsp_instr,
    output logic                mem_req_valid,
    output logic [ADDR_W-1:0]   mem_req_addr,
    input  logic                mem_req_ready,
    input  logic                mem_rsp_valid,
    input  logic [LINE_W-1:0]   mem_rsp_data,
    output t_cache_ctrl_plru    cache_ctrl_plru,
    input  logic [WAY_W-1:0]    evicted_cl,
    output logic [31:0]         hit_cnt,
    output logic [31:0]         miss_cnt
);

    t_ifu_cache_state               state_q, state_d;
    logic [ADDR_W-1:0]              addr_q;
    logic [WAY_W-1:0]               victim_q;
    t_ifu_tag_entry [WAYS_NUM-1:0]  tag_q;
    logic [LINE_W-1:0]              data_q [WAYS_NUM];
    logic                           rsp_valid_q;
    logic [INSTR_W-1:0]             rsp_instr_q;

    logic [WAYS_NUM-1:0]            match;
    logic                           hit;
    logic [WAY_W-1:0]               hit_way;
    logic [TAG_W-1:0]               lookup_tag;
    logic                           accept;
    logic                           flush_take;
    logic                           refill;
    logic                           unused_addr_bits;

    assign lookup_tag       = addr_q[ADDR_W-1:OFFS_W];
    assign unused_addr_bits = ^addr_q[1:0];

    ifu_tag_cmp u_tag_cmp (
        .entries (tag_q),
        .tag     (lookup_tag),
        .match   (match),
        .hit     (hit),
        .way     (hit_way)
    );

    always_comb begin
        state_d         = state_q;
        fetch_req_ready = 1'b0;
        mem_req_valid   = 1'b0;
        cache_ctrl_plru = '0;
        accept          = 1'b0;
        flush_take      = 1'b0;
        refill          = 1'b0;
        case (state_q)
            IDLE: begin
                fetch_req_ready = !flush;
                flush_take      = flush;
                accept          = fetch_req_valid && !flush;
                if (accept) state_d = LOOKUP;
            end
            LOOKUP: begin
                cache_ctrl_plru.update_tree = 1'b1;
                if (hit) begin
                    cache_ctrl_plru.hit_cl = hit_way;
                    state_d                = IDLE;
                end else begin
                    // single-cycle pulse: the plru fill counter steps once per miss cycle
                    cache_ctrl_plru.cache_miss = 1'b1;
                    state_d                    = MISS_REQ;
                end
            end
            MISS_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = MISS_WAIT;
            end
            MISS_WAIT: begin
                refill = mem_rsp_valid;
                if (mem_rsp_valid) state_d = LOOKUP;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_req_addr    = {addr_q[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
    assign fetch_rsp_valid = rsp_valid_q;
    assign fetch_rsp_instr = rsp_instr_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= (state_q == LOOKUP) && hit;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < WAYS_NUM; i++) tag_q[i].valid <= 1'b0;
        end else if (flush_take) begin
            for (int i = 0; i < WAYS_NUM; i++) tag_q[i].valid <= 1'b0;
        end else if (refill) begin
            tag_q[victim_q].valid <= 1'b1;
            tag_q[victim_q].tag   <= lookup_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) addr_q <= fetch_req_addr;
        if (cache_ctrl_plru.cache_miss) victim_q <= evicted_cl;
        if (refill) data_q[victim_q] <= mem_rsp_data;
        if ((state_q == LOOKUP) && hit)
            rsp_instr_q <= data_q[hit_way][addr_q[3:2]*INSTR_W +: INSTR_W];
    end

`ifdef IFU_CACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;
    logic        replay_q;

    // the lookup that follows a refill is a guaranteed hit and is not counted
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            replay_q   <= 1'b0;
        end else begin
            if (refill) replay_q <= 1'b1;
            else if (state_q == LOOKUP) replay_q <= 1'b0;
            if ((state_q == LOOKUP) && hit && !replay_q && (hit_cnt_q != '1))
                hit_cnt_q <= hit_cnt_q + 32'd1;
            if (cache_ctrl_plru.cache_miss && (miss_cnt_q != '1))
                miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

    a_single_match: assert property (@(posedge clk) disable iff (!rst)
        (state_q == LOOKUP) |-> $onehot0(match));

endmodule

// File: tb/tb_ifu_cache_ctrl.sv
// Bench for ifu_cache_ctrl: behavioural cache/memory model plus a tree-plru peer
// that supplies evicted_cl, directed scenarios and a randomized fetch mix.
module tb_ifu_cache_ctrl;
    import ifu_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               flush = 1'b0;
    logic               fetch_req_valid = 1'b0;
    logic [31:0]        fetch_req_addr = '0;
    logic               fetch_req_ready;
    logic               fetch_rsp_valid;
    logic [31:0]        fetch_rsp_instr;
    logic               mem_req_valid;
    logic [31:0]        mem_req_addr;
    logic               mem_req_ready = 1'b0;
    logic               mem_rsp_valid = 1'b0;
    logic [127:0]       mem_rsp_data = '0;
    t_cache_ctrl_plru   cache_ctrl_plru;
    logic [3:0]         evicted_cl;
    logic [31:0]        hit_cnt, miss_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifu_cache_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fetch_req_valid(fetch_req_valid), .fetch_req_addr(fetch_req_addr),
        .fetch_req_ready(fetch_req_ready),
        .fetch_rsp_valid(fetch_rsp_valid), .fetch_rsp_instr(fetch_rsp_instr),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .cache_ctrl_plru(cache_ctrl_plru), .evicted_cl(evicted_cl),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // ---------------- plru peer: fill ways in order, then binary-tree pseudo-LRU
    bit         tr [16];
    int         fill = 0;
    logic [3:0] pl_victim = '0;
    bit         pend_upd = 0;
    bit         pend_miss = 0;
    logic [3:0] pend_way = '0;

    function automatic logic [3:0] tree_pick();
        int node = 1;
        for (int l = 0; l < 4; l++) node = 2 * node + int'(tr[node]);
        return 4'(node - 16);
    endfunction

    always @(negedge clk) begin
        pend_upd  = cache_ctrl_plru.update_tree;
        pend_miss = cache_ctrl_plru.cache_miss;
        pend_way  = cache_ctrl_plru.cache_miss ? evicted_cl : cache_ctrl_plru.hit_cl;
    end

    always @(posedge clk) begin
        if (!rst) begin
            fill = 0;
            for (int i = 0; i < 16; i++) tr[i] = 0;
            pend_upd = 0;
        end else if (pend_upd) begin
            int node = int'(pend_way) + 16;
            while (node > 1) begin
                tr[node / 2] = (node % 2 == 0);
                node = node / 2;
            end
            if (pend_miss && fill < 16) fill++;
            pend_upd = 0;
        end
        pl_victim <= (fill < 16) ? 4'(fill) : tree_pick();
    end

    assign evicted_cl = pl_victim;

    // ---------------- cache and memory model
    bit          m_valid [16];
    logic [27:0] m_tag   [16];
    int          m_hits = 0;
    int          m_misses = 0;

    function automatic logic [127:0] line_data(input logic [31:0] a);
        logic [127:0] d;
        logic [31:0]  base;
        base = a & 32'hFFFF_FFF0;
        for (int k = 0; k < 4; k++) d[k*32 +: 32] = base ^ (32'h9E37_79B9 * 32'(k + 1));
        if (base == 32'h0000_1000) d[63:32] = 32'hDEAD_BEEF;
        return d;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [127:0] d;
        d = line_data(a);
        return d[a[3:2]*32 +: 32];
    endfunction

    task automatic model_lookup(input logic [31:0] a, output bit h, output logic [3:0] w);
        h = 0;
        w = '0;
        for (int i = 0; i < 16; i++)
            if (m_valid[i] && m_tag[i] == a[31:4]) begin
                h = 1;
                w = 4'(i);
            end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 0;
    endtask

    // ---------------- fetch driver: collects observations only
    typedef struct {
        int          misses;
        logic [3:0]  way;
        bit          mem_seen;
        logic [31:0] mem_addr;
        bit          addr_stable;
        int          req_cycles;
        int          lat;
        int          rsp_lat;
        logic [31:0] instr;
        bit          ready_at_rsp;
        bit          timeout;
    } fres_t;

    task automatic run_fetch(input logic [31:0] a, input int rdy_delay, input int rsp_delay,
                             output fres_t r);
        bit hs_pending = 0;
        int rsp_cd = -1;
        int rsp_c = -1;
        int w = 0;
        r = '{default: 0};
        r.addr_stable = 1;
        r.timeout = 1;
        @(negedge clk);
        fetch_req_valid = 1;
        fetch_req_addr  = a;
        while (!fetch_req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            fetch_req_valid = 0;
            if (cache_ctrl_plru.cache_miss) r.misses++;
            if (cache_ctrl_plru.update_tree && !cache_ctrl_plru.cache_miss)
                r.way = cache_ctrl_plru.hit_cl;
            if (fetch_rsp_valid) begin
                r.instr        = fetch_rsp_instr;
                r.lat          = c;
                r.rsp_lat      = (rsp_c >= 0) ? c - rsp_c : -1;
                r.ready_at_rsp = fetch_req_ready;
                r.timeout      = 0;
                break;
            end
            mem_rsp_valid = 0;
            if (hs_pending) begin
                mem_req_ready = 0;
                hs_pending    = 0;
                rsp_cd        = rsp_delay;
            end
            if (rsp_cd == 0) begin
                mem_rsp_valid = 1;
                mem_rsp_data  = line_data(a);
                rsp_c  = c;
                rsp_cd = -1;
            end else if (rsp_cd > 0) begin
                rsp_cd--;
            end
            if (mem_req_valid) begin
                if (!r.mem_seen) r.mem_addr = mem_req_addr;
                else if (mem_req_addr !== r.mem_addr) r.addr_stable = 0;
                r.mem_seen = 1;
                r.req_cycles++;
                if (r.req_cycles > rdy_delay) begin
                    mem_req_ready = 1;
                    hs_pending    = 1;
                end
            end
        end
        mem_req_ready = 0;
        mem_rsp_valid = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        flush = 0;
        fetch_req_valid = 0;
        mem_req_ready = 0;
        mem_rsp_valid = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        model_clear();
        m_hits = 0;
        m_misses = 0;
        @(negedge clk);
    endtask

    // ---------------- scenarios
    task automatic test_reset();
        do_reset();
        checks++;
        if (fetch_req_ready !== 1'b1 || fetch_rsp_valid !== 1'b0 || mem_req_valid !== 1'b0 ||
            cache_ctrl_plru !== '0 || hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: ready=%b rsp_v=%b mreq_v=%b plru=%h hc=%0d mc=%0d, required 1 0 0 0 0 0",
                     fetch_req_ready, fetch_rsp_valid, mem_req_valid, cache_ctrl_plru, hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_first_miss();
        fres_t r;
        logic [3:0] exp_v = pl_victim;
        run_fetch(32'h0000_1004, 0, 1, r);
        checks++;
        if (r.timeout || r.misses != 1 || r.way !== exp_v) begin
            errors++;
            $display("FAIL first_miss_pulse: to=%0b pulses=%0d way=%0d, required 0 1 %0d",
                     r.timeout, r.misses, r.way, exp_v);
        end
        checks++;
        if (r.mem_addr !== 32'h0000_1000) begin
            errors++;
            $display("FAIL first_miss_addr: got %h, required %h", r.mem_addr, 32'h0000_1000);
        end
        checks++;
        if (r.instr !== mem_word(32'h0000_1004) || r.rsp_lat != 2) begin
            errors++;
            $display("FAIL first_miss_rsp: instr=%h lat=%0d, required %h 2",
                     r.instr, r.rsp_lat, mem_word(32'h0000_1004));
        end
        m_valid[exp_v] = 1;
        m_tag[exp_v]   = 28'h000_0100;
        m_misses++;
    endtask

    task automatic test_hit();
        fres_t r;
        bit h;
        logic [3:0] w;
        model_lookup(32'h0000_1008, h, w);
        run_fetch(32'h0000_1008, 0, 0, r);
        checks++;
        if (r.timeout || !h || r.misses != 0 || r.mem_seen || r.way !== w) begin
            errors++;
            $display("FAIL hit_path: to=%0b model_hit=%0b pulses=%0d mreq=%0b way=%0d, required 0 1 0 0 %0d",
                     r.timeout, h, r.misses, r.mem_seen, r.way, w);
        end
        checks++;
        if (r.lat != 2 || !r.ready_at_rsp || r.instr !== mem_word(32'h0000_1008)) begin
            errors++;
            $display("FAIL hit_timing: lat=%0d ready=%0b instr=%h, required 2 1 %h",
                     r.lat, r.ready_at_rsp, r.instr, mem_word(32'h0000_1008));
        end
        m_hits++;
        checks++;
`ifdef IFU_CACHE_PERF_CNT_EN
        if (hit_cnt !== 32'(m_hits) || miss_cnt !== 32'(m_misses)) begin
            errors++;
            $display("FAIL perf_after_hit: hit_cnt=%0d miss_cnt=%0d, required %0d %0d",
                     hit_cnt, miss_cnt, m_hits, m_misses);
        end
`else
        if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            errors++;
            $display("FAIL perf_disabled: hit_cnt=%0d miss_cnt=%0d, required 0 0", hit_cnt, miss_cnt);
        end
`endif
    endtask

    task automatic test_fill_evict();
        fres_t r;
        logic [3:0] exp_v;
        logic [31:0] a;
        logic [27:0] evicted_tag = '0;
        bit h;
        logic [3:0] w;
        do_reset();
        for (int k = 0; k < 17; k++) begin
            a = 32'h100 * 32'(k) + 32'($urandom_range(0, 3) << 2);
            exp_v = pl_victim;
            if (m_valid[exp_v]) evicted_tag = m_tag[exp_v];
            run_fetch(a, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), r);
            checks++;
            if (r.timeout || r.misses != 1 || r.way !== exp_v || r.instr !== mem_word(a) ||
                r.mem_addr !== (a & 32'hFFFF_FFF0)) begin
                errors++;
                $display("FAIL fill_line%0d: to=%0b pulses=%0d way=%0d instr=%h maddr=%h, required 0 1 %0d %h %h",
                         k, r.timeout, r.misses, r.way, r.instr, r.mem_addr, exp_v, mem_word(a),
                         a & 32'hFFFF_FFF0);
            end
            m_valid[exp_v] = 1;
            m_tag[exp_v]   = a[31:4];
            m_misses++;
        end
        a = {evicted_tag, 4'h4};
        model_lookup(a, h, w);
        run_fetch(a, 0, 0, r);
        checks++;
        if (h || r.misses != 1 || r.instr !== mem_word(a)) begin
            errors++;
            $display("FAIL evicted_refetch: model_hit=%0b pulses=%0d instr=%h, required 0 1 %h",
                     h, r.misses, r.instr, mem_word(a));
        end
        exp_v = w;
        m_misses++;
    endtask

    task automatic fix_model_after_refetch(input logic [31:0] a, input logic [3:0] v);
        m_valid[v] = 1;
        m_tag[v]   = a[31:4];
    endtask

    task automatic test_backpressure();
        fres_t r;
        logic [31:0] a = 32'h0000_7A0C;
        logic [3:0] exp_v = pl_victim;
        run_fetch(a, 5, 1, r);
        checks++;
        if (r.timeout || r.misses != 1 || !r.addr_stable || r.req_cycles != 6 ||
            r.mem_addr !== 32'h0000_7A00) begin
            errors++;
            $display("FAIL backpressure: to=%0b pulses=%0d stable=%0b req_cycles=%0d maddr=%h, required 0 1 1 6 %h",
                     r.timeout, r.misses, r.addr_stable, r.req_cycles, r.mem_addr, 32'h0000_7A00);
        end
        checks++;
        if (r.instr !== mem_word(a) || r.way !== exp_v) begin
            errors++;
            $display("FAIL backpressure_rsp: instr=%h way=%0d, required %h %0d",
                     r.instr, r.way, mem_word(a), exp_v);
        end
        fix_model_after_refetch(a, exp_v);
        m_misses++;
    endtask

    task automatic test_flush();
        fres_t r;
        bit h;
        logic [3:0] w;
        logic [31:0] a = 32'h0000_7A08;
        bit seen_activity = 0;
        model_lookup(a, h, w);
        @(negedge clk);
        flush = 1;
        fetch_req_valid = 1;
        fetch_req_addr = a;
        #1;
        checks++;
        if (fetch_req_ready !== 1'b0 || !h) begin
            errors++;
            $display("FAIL flush_ready: ready=%b model_hit=%0b, required 0 1", fetch_req_ready, h);
        end
        @(negedge clk);
        flush = 0;
        fetch_req_valid = 0;
        repeat (3) begin
            if (cache_ctrl_plru !== '0 || fetch_rsp_valid !== 1'b0) seen_activity = 1;
            @(negedge clk);
        end
        checks++;
        if (seen_activity) begin
            errors++;
            $display("FAIL flush_priority: lookup/response observed after flush, required none");
        end
        model_clear();
        w = pl_victim;
        run_fetch(a, 0, 0, r);
        checks++;
        if (r.misses != 1 || r.instr !== mem_word(a)) begin
            errors++;
            $display("FAIL flush_refetch: pulses=%0d instr=%h, required 1 %h", r.misses, r.instr, mem_word(a));
        end
        fix_model_after_refetch(a, w);
        m_misses++;
    endtask

    task automatic test_random();
        fres_t r;
        bit h;
        logic [3:0] w;
        logic [3:0] exp_v;
        logic [31:0] a;
        for (int n = 0; n < 60; n++) begin
            a = 32'h4000_0000 + 32'($urandom_range(0, 23) << 4) + 32'($urandom_range(0, 3) << 2);
            model_lookup(a, h, w);
            exp_v = pl_victim;
            run_fetch(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), r);
            checks++;
            if (h) begin
                if (r.timeout || r.misses != 0 || r.mem_seen || r.way !== w || r.lat != 2 ||
                    r.instr !== mem_word(a)) begin
                    errors++;
                    $display("FAIL rand_hit%0d a=%h: to=%0b pulses=%0d mreq=%0b way=%0d lat=%0d instr=%h, required 0 0 0 %0d 2 %h",
                             n, a, r.timeout, r.misses, r.mem_seen, r.way, r.lat, r.instr, w, mem_word(a));
                end
                m_hits++;
            end else begin
                if (r.timeout || r.misses != 1 || r.way !== exp_v || r.rsp_lat != 2 ||
                    r.mem_addr !== (a & 32'hFFFF_FFF0) || r.instr !== mem_word(a)) begin
                    errors++;
                    $display("FAIL rand_miss%0d a=%h: to=%0b pulses=%0d way=%0d lat=%0d maddr=%h instr=%h, required 0 1 %0d 2 %h %h",
                             n, a, r.timeout, r.misses, r.way, r.rsp_lat, r.mem_addr, r.instr, exp_v,
                             a & 32'hFFFF_FFF0, mem_word(a));
                end
                fix_model_after_refetch(a, exp_v);
                m_misses++;
            end
        end
        checks++;
`ifdef IFU_CACHE_PERF_CNT_EN
        if (hit_cnt !== 32'(m_hits) || miss_cnt !== 32'(m_misses)) begin
            errors++;
            $display("FAIL perf_random: hit_cnt=%0d miss_cnt=%0d, required %0d %0d",
                     hit_cnt, miss_cnt, m_hits, m_misses);
        end
`else
        if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            errors++;
            $display("FAIL perf_random_disabled: hit_cnt=%0d miss_cnt=%0d, required 0 0", hit_cnt, miss_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid_miss();
        fres_t r;
        logic [31:0] a = 32'h0000_9C04;
        int n = 0;
        bit seen_activity = 0;
        @(negedge clk);
        fetch_req_valid = 1;
        fetch_req_addr = a;
        @(negedge clk);
        fetch_req_valid = 0;
        while (!mem_req_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!mem_req_valid) begin
            errors++;
            $display("FAIL midmiss_req: mem_req_valid=%b after %0d cycles, required 1", mem_req_valid, n);
        end
        mem_req_ready = 1;
        @(negedge clk);
        mem_req_ready = 0;
        rst = 0;
        @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b0 || fetch_req_ready !== 1'b1 || hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            errors++;
            $display("FAIL midmiss_reset: mreq_v=%b ready=%b hc=%0d mc=%0d, required 0 1 0 0",
                     mem_req_valid, fetch_req_ready, hit_cnt, miss_cnt);
        end
        rst = 1;
        mem_rsp_valid = 1;
        mem_rsp_data = line_data(a);
        model_clear();
        m_hits = 0;
        m_misses = 0;
        @(negedge clk);
        mem_rsp_valid = 0;
        repeat (3) begin
            if (cache_ctrl_plru !== '0 || fetch_rsp_valid !== 1'b0 || mem_req_valid !== 1'b0)
                seen_activity = 1;
            @(negedge clk);
        end
        checks++;
        if (seen_activity) begin
            errors++;
            $display("FAIL midmiss_stray_rsp: activity after reset+stray response, required none");
        end
        run_fetch(a, 0, 0, r);
        checks++;
        if (r.misses != 1 || r.instr !== mem_word(a)) begin
            errors++;
            $display("FAIL midmiss_refetch: pulses=%0d instr=%h, required 1 %h", r.misses, r.instr, mem_word(a));
        end
    endtask

    initial begin
        test_reset();
        test_first_miss();
        test_hit();
        test_fill_evict();
        test_backpressure();
        test_flush();
        test_random();
        test_reset_mid_miss();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
